elevator_controller: RTL and testbench
======================================

Name: elevator_controller

Overview:
- Sequential controller for a single 8-floor elevator car.
- Latches hall/car call buttons into a pending-call register and tracks car position.
- Sequences motion (SCAN policy: keep direction while calls exist ahead, else reverse) and door dwell.
- Feeds current_floor/calls_pending to the combinational direction/count/floor-check datapath; its own decisions use the same above/below/at-floor partition of the call vector.

Parameters:
- TRAVEL_CYCLES, 4, clock cycles spent moving between adjacent floors (>=1, <=255)
- DOOR_CYCLES, 6, clock cycles doors stay open per stop (>=1, <=255)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- call_req  in  8  one bit per floor; 1 in a cycle = call for that floor (pulse or level)
- current_floor  out  3  registered car position, 0..7
- calls_pending  out  8  registered pending-call vector
- moving  out  1  1 in state UP or DOWN
- going_up  out  1  direction register (last/current travel direction)
- door_open  out  1  1 in state DOOR
- state  out  2  IDLE=0, UP=1, DOWN=2, DOOR=3

Behaviour:
- Reset (async, immediate): state=IDLE, current_floor=0, calls_pending=0, going_up=1, moving=0, door_open=0, timers=0.
- Call latch: each cycle calls_pending <= calls_pending | call_req, except:
  - In DOOR, the call_req bit for current_floor is ignored: not latched, dwell not extended.
  - On the transition into DOOR, the bit for the arrival floor is cleared; clear wins over a same-cycle set.
- Request-to-reaction latency is 1 cycle. Decisions use registered calls_pending only.
- Derived each cycle:
  - above = any pending bit > current_floor
  - below = any pending bit < current_floor
  - here = pending bit at current_floor
- Decision function D, evaluated in IDLE, at DOOR expiry, and at MOVE arrival:
  - here -> DOOR
  - else going_up & above -> UP
  - else ~going_up & below -> DOWN
  - else above -> UP with going_up<=1
  - else below -> DOWN with going_up<=0
  - else -> IDLE
- IDLE: apply D every cycle.
- UP/DOWN:
  - On entry, the travel timer loads TRAVEL_CYCLES-1 and decrements each cycle.
  - When the timer is 0: current_floor <= current_floor +/- 1, then apply D using the new floor.
  - here at the new floor -> DOOR in the same edge (arrival and DOOR are visible together).
  - Continuing in the same direction reloads the timer.
  - Moving past floor 7 (up) or below floor 0 (down) is impossible because motion requires above/below; the implementation asserts this in simulation.
- DOOR:
  - On entry, the door timer loads DOOR_CYCLES-1; door_open=1 for exactly DOOR_CYCLES cycles.
  - At timer 0: apply D. "here" cannot be true at that point, so the result is UP, DOWN or IDLE.
- going_up changes only via D reversal; reset value is 1.
- Reset asserted mid-move or mid-dwell: everything returns to reset values immediately, pending calls are lost, and the car is reported at floor 0.
- Timers are 8-bit and saturate at 0. No wrap-around on current_floor.

Test Plan:
- Reset, then call_req=0x08 pulsed at t0 -> t1 calls_pending=0x08; t2 state=UP, moving=1. current_floor=1@t6, 2@t10, 3@t14. At t14 state=DOOR, door_open=1, calls_pending=0x00. door_open stays high t14..t19; t20 state=IDLE.
- At floor 3 idle, calls 0x81 (floors 0 and 7) set together, going_up=1 -> goes UP to 7, dwells, then reverses (going_up=0) to floor 0. calls_pending=0x00 at end.
- While moving up from 2 to 6 (call 0x40), call 0x04 (floor 2) arrives -> car continues to 6, opens, then travels DOWN to 2. Floor-2 bit stays set until arrival at 2.
- Car in DOOR at floor 5, call_req=0x20 held for 3 cycles -> bit not latched, door_open high exactly 6 cycles, then IDLE.
- Call for current floor 0 while IDLE -> state=DOOR 2 cycles after the request edge, with no movement.
- Assert reset during UP at floor 2 -> same-cycle (async) state=IDLE, current_floor=0, calls_pending=0, going_up=1, door_open=0.

Source files
------------

// File: rtl/elevator_controller.sv
// ----------------------------------------------------------------------------
// elevator_controller
//   Controller for a single 8-floor elevator car. It latches call buttons into
//   a pending-call vector, tracks car position, and sequences motion with a SCAN
//   policy: keep going while calls lie ahead, otherwise reverse. Each stop gets
//   a fixed door dwell.
//
// Parameters
//   TRAVEL_CYCLES  clock cycles spent moving between adjacent floors (1..255)
//   DOOR_CYCLES    clock cycles the door stays open per stop (1..255)
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-high reset
//   call_req[7:0]  call request, one bit per floor (pulse or level)
//   current_floor  registered car position, 0..7
//   calls_pending  registered pending-call vector
//   moving         1 while in UP or DOWN
//   going_up       direction register (last or current travel direction)
//   door_open      1 while in DOOR
//   state          IDLE=0, UP=1, DOWN=2, DOOR=3
// ----------------------------------------------------------------------------
module elevator_controller #(
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] call_req,
   output logic [2:0] current_floor,
   output logic [7:0] calls_pending,
   output logic       moving,
   output logic       going_up,
   output logic       door_open,
   output logic [1:0] state
);

   localparam int unsigned FLOORS = 8;
   localparam int unsigned FW     = 3;
   localparam int unsigned TW     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DOOR = 2'd3
   } state_t;

   state_t            st;
   logic [TW-1:0]     travel_timer;
   logic [TW-1:0]     door_timer;

   logic [FW-1:0]     eval_floor;
   logic              decide_now;
   logic              above;
   logic              below;
   logic              here;
   state_t            dec_state;
   logic              dec_up;
   logic [FLOORS-1:0] req_masked;
   logic [FLOORS-1:0] pend_set;

   assign state = st;

   // Decision points and the floor the decision is taken for: in motion this
   // is the arrival floor, so the car can open its door on the arrival edge.
   always_comb begin
      eval_floor = current_floor;
      decide_now = 1'b0;
      case (st)
         IDLE: decide_now = 1'b1;
         UP: begin
            decide_now = (travel_timer == '0);
            if (decide_now) eval_floor = current_floor + FW'(1);
         end
         DOWN: begin
            decide_now = (travel_timer == '0);
            if (decide_now) eval_floor = current_floor - FW'(1);
         end
         DOOR: decide_now = (door_timer == '0);
         default: decide_now = 1'b0;
      endcase
   end

   // Partition the registered call vector around the evaluation floor.
   always_comb begin
      above = 1'b0;
      below = 1'b0;
      here  = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (calls_pending[i]) begin
            if (FW'(i) > eval_floor)      above = 1'b1;
            else if (FW'(i) < eval_floor) below = 1'b1;
            else                          here  = 1'b1;
         end
      end
   end

   // SCAN decision: serve here, keep direction while calls lie ahead, else reverse.
   always_comb begin
      dec_state = IDLE;
      dec_up    = going_up;
      if (here) begin
         dec_state = DOOR;
      end else if (going_up && above) begin
         dec_state = UP;
      end else if (!going_up && below) begin
         dec_state = DOWN;
      end else if (above) begin
         dec_state = UP;
         dec_up    = 1'b1;
      end else if (below) begin
         dec_state = DOWN;
         dec_up    = 1'b0;
      end
   end

   // A call for the floor whose door is already open is simply dropped.
   always_comb begin
      req_masked = call_req;
      if (st == DOOR) req_masked[current_floor] = 1'b0;
      pend_set = calls_pending | req_masked;
   end

   // State, position, timers and registered status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st            <= IDLE;
         current_floor <= '0;
         calls_pending <= '0;
         going_up      <= 1'b1;
         moving        <= 1'b0;
         door_open     <= 1'b0;
         travel_timer  <= '0;
         door_timer    <= '0;
      end else begin
         calls_pending <= pend_set;
         case (st)
            UP, DOWN: if (travel_timer != '0) travel_timer <= travel_timer - TW'(1);
            DOOR:     if (door_timer != '0)   door_timer   <= door_timer - TW'(1);
            default: ;
         endcase
         if (decide_now) begin
            st            <= dec_state;
            going_up      <= dec_up;
            current_floor <= eval_floor;
            moving        <= (dec_state == UP) || (dec_state == DOWN);
            door_open     <= (dec_state == DOOR);
            if (dec_state == DOOR) begin
               door_timer <= TW'(DOOR_CYCLES - 1);
               // Clearing the served floor overrides a same-cycle request for it.
               calls_pending <= pend_set & ~(FLOORS'(1) << eval_floor);
            end
            if ((dec_state == UP) || (dec_state == DOWN))
               travel_timer <= TW'(TRAVEL_CYCLES - 1);
         end
      end
   end

   // Motion is only ever started toward a pending call, so the car never runs
   // off either end of the shaft.
   assert property (@(posedge clock) disable iff (reset)
      !((st == UP) && (travel_timer == '0) && (current_floor == 3'd7)));
   assert property (@(posedge clock) disable iff (reset)
      !((st == DOWN) && (travel_timer == '0) && (current_floor == 3'd0)));

endmodule

// File: tb/tb_elevator_controller.sv
// ----------------------------------------------------------------------------
// tb_elevator_controller
//   Self-checking bench for elevator_controller. A behavioural model of the car
//   (integers and bit arithmetic on the call vector) is stepped on every clock
//   edge alongside the DUT; scenario tasks check both fixed expected values and
//   the model's view of the outputs.
// ----------------------------------------------------------------------------
module tb_elevator_controller;

   localparam int TRAVEL = 4;
   localparam int DWELL  = 6;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] call_req;
   logic [2:0] current_floor;
   logic [7:0] calls_pending;
   logic       moving;
   logic       going_up;
   logic       door_open;
   logic [1:0] state;

   logic [15:0] obs;
   assign obs = {state, current_floor, calls_pending, moving, going_up, door_open};

   int checks = 0;
   int errors = 0;

   // model state: 0 idle, 1 up, 2 down, 3 door
   int         m_state;
   int         m_floor;
   int         m_up;
   int         m_timer;
   logic [7:0] m_pend;

   elevator_controller #(
      .TRAVEL_CYCLES(TRAVEL),
      .DOOR_CYCLES  (DWELL)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .call_req     (call_req),
      .current_floor(current_floor),
      .calls_pending(calls_pending),
      .moving       (moving),
      .going_up     (going_up),
      .door_open    (door_open),
      .state        (state)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_state = 0;
      m_floor = 0;
      m_up    = 1;
      m_timer = 0;
      m_pend  = 8'h00;
   endfunction

   // SCAN choice for a car at floor f with call vector p and direction u.
   function automatic void decide(input int f, input logic [7:0] p, input int u,
                                  output int ns, output int nu);
      bit above, below, here;
      above = ((int'(p) >> (f + 1)) != 0);
      below = ((int'(p) & ((1 << f) - 1)) != 0);
      here  = p[3'(f)];
      nu = u;
      if (here)                 ns = 3;
      else if (u == 1 && above) ns = 1;
      else if (u == 0 && below) ns = 2;
      else if (above) begin ns = 1; nu = 1; end
      else if (below) begin ns = 2; nu = 0; end
      else                      ns = 0;
   endfunction

   function automatic void model_step(input logic [7:0] req);
      logic [7:0] reqm;
      logic [7:0] newp;
      int f, ns, nu;
      bit ev;
      reqm = req;
      if (m_state == 3) reqm[3'(m_floor)] = 1'b0;
      newp = m_pend | reqm;
      f  = m_floor;
      ev = 0;
      ns = 0;
      nu = m_up;
      case (m_state)
         0: ev = 1;
         1, 2: begin
            if (m_timer == 0) begin
               ev = 1;
               f  = (m_state == 1) ? m_floor + 1 : m_floor - 1;
            end else m_timer = m_timer - 1;
         end
         default: begin
            if (m_timer == 0) ev = 1;
            else m_timer = m_timer - 1;
         end
      endcase
      if (ev) begin
         decide(f, m_pend, m_up, ns, nu);
         m_floor = f;
         m_up    = nu;
         m_state = ns;
         if (ns == 3) begin
            newp[3'(f)] = 1'b0;
            m_timer = DWELL - 1;
         end else if (ns != 0) begin
            m_timer = TRAVEL - 1;
         end
      end
      m_pend = newp;
   endfunction

   function automatic logic [15:0] exp_vec();
      return {2'(m_state), 3'(m_floor), m_pend, 1'(m_state == 1 || m_state == 2),
              1'(m_up), 1'(m_state == 3)};
   endfunction

   // One clock: present req at the next edge, advance the model, settle.
   task automatic tick(input logic [7:0] req);
      call_req = req;
      @(posedge clock);
      model_step(req);
      #1;
   endtask

   // Run with no new calls until the car is idle with nothing pending.
   task automatic run_to_idle(input int bound, output bit ok);
      ok = 0;
      for (int n = 0; n < bound; n++) begin
         tick(8'h00);
         if (state == 2'd0 && calls_pending == 8'h00) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      call_req = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      model_reset();
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++;
      if (current_floor !== 3'd0) begin errors++; $display("FAIL reset_floor: got %0d expected 0", current_floor); end
      checks++;
      if (calls_pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", calls_pending); end
      checks++;
      if ({going_up, moving, door_open} !== 3'b100) begin
         errors++; $display("FAIL reset_flags: got %b expected 100", {going_up, moving, door_open});
      end
      reset = 1'b0;
   endtask

   task automatic test_single_call();
      tick(8'h08);
      checks++;
      if (calls_pending !== 8'h08) begin errors++; $display("FAIL t1_pending: got %h expected 08", calls_pending); end
      for (int t = 2; t <= 20; t++) begin
         tick(8'h00);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL single_model t=%0d: got %h expected %h", t, obs, exp_vec()); end
         if (t == 2) begin
            checks++;
            if (state !== 2'd1 || moving !== 1'b1) begin
               errors++; $display("FAIL t2_up: got state=%0d moving=%b expected state=1 moving=1", state, moving);
            end
         end
         if (t == 6 || t == 10 || t == 14) begin
            checks++;
            if (current_floor !== 3'((t - 2) / 4)) begin
               errors++; $display("FAIL t%0d_floor: got %0d expected %0d", t, current_floor, (t - 2) / 4);
            end
         end
         if (t == 14) begin
            checks++;
            if (state !== 2'd3 || calls_pending !== 8'h00) begin
               errors++; $display("FAIL t14_door: got state=%0d pending=%h expected state=3 pending=00", state, calls_pending);
            end
         end
         if (t >= 14 && t <= 19) begin
            checks++;
            if (door_open !== 1'b1) begin errors++; $display("FAIL t%0d_door_open: got %b expected 1", t, door_open); end
         end
         if (t == 20) begin
            checks++;
            if (state !== 2'd0 || door_open !== 1'b0) begin
               errors++; $display("FAIL t20_idle: got state=%0d door_open=%b expected 0 0", state, door_open);
            end
         end
      end
   endtask

   task automatic test_sweep();
      int door7 = -1;
      int door0 = -1;
      bit done = 0;
      tick(8'h81);
      for (int n = 0; n < 200 && !done; n++) begin
         tick(8'h00);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL sweep_model n=%0d: got %h expected %h", n, obs, exp_vec()); end
         if (state == 2'd3 && current_floor == 3'd7 && door7 < 0) door7 = n;
         if (state == 2'd3 && current_floor == 3'd0 && door0 < 0) door0 = n;
         if (door0 >= 0 && state == 2'd0) done = 1;
      end
      checks++;
      if (!done || door7 < 0 || door0 <= door7) begin
         errors++; $display("FAIL sweep_order: got door7@%0d door0@%0d done=%b expected 7 before 0", door7, door0, done);
      end
      checks++;
      if ({current_floor, going_up, calls_pending} !== {3'd0, 1'b0, 8'h00}) begin
         errors++; $display("FAIL sweep_end: got floor=%0d up=%b pending=%h expected 0 0 00", current_floor, going_up, calls_pending);
      end
   endtask

   task automatic test_mid_move_call();
      bit ok;
      int door6 = -1;
      int door2 = -1;
      int n = 0;
      tick(8'h04);
      run_to_idle(100, ok);
      checks++;
      if (!ok || current_floor !== 3'd2) begin errors++; $display("FAIL mid_setup: got floor=%0d ok=%b expected floor=2", current_floor, ok); end
      tick(8'h40);
      while (n < 50 && !(state == 2'd1 && current_floor == 3'd3)) begin tick(8'h00); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL mid_reach3: got floor=%0d state=%0d expected floor 3 moving up", current_floor, state); end
      tick(8'h04);
      for (int k = 0; k < 150; k++) begin
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL mid_model k=%0d: got %h expected %h", k, obs, exp_vec()); end
         if (state == 2'd3 && current_floor == 3'd6 && door6 < 0) door6 = k;
         if (state == 2'd3 && current_floor == 3'd2 && door2 < 0) door2 = k;
         if (door2 < 0) begin
            checks++;
            if (calls_pending[2] !== 1'b1) begin errors++; $display("FAIL mid_bit2_held k=%0d: got 0 expected 1", k); end
         end
         if (door2 >= 0 && state == 2'd0) break;
         tick(8'h00);
      end
      checks++;
      if (door6 < 0 || door2 <= door6) begin
         errors++; $display("FAIL mid_order: got door6@%0d door2@%0d expected 6 before 2", door6, door2);
      end
      checks++;
      if (state !== 2'd0 || current_floor !== 3'd2 || calls_pending !== 8'h00) begin
         errors++; $display("FAIL mid_end: got state=%0d floor=%0d pending=%h expected 0 2 00", state, current_floor, calls_pending);
      end
   endtask

   task automatic test_door_hold();
      int n = 0;
      int open_cycles = 0;
      tick(8'h20);
      while (n < 100 && state != 2'd3) begin tick(8'h00); n++; end
      checks++;
      if (state !== 2'd3 || current_floor !== 3'd5) begin
         errors++; $display("FAIL hold_arrive: got state=%0d floor=%0d expected 3 5", state, current_floor);
      end
      if (door_open) open_cycles = 1;
      for (int k = 0; k < 3; k++) begin
         tick(8'h20);
         checks++;
         if (calls_pending[5] !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL hold_ignore k=%0d: got %h expected %h", k, obs, exp_vec());
         end
         if (door_open) open_cycles++;
      end
      for (int k = 0; k < 20; k++) begin
         tick(8'h00);
         if (door_open) open_cycles++;
         else break;
      end
      checks++;
      if (open_cycles != DWELL) begin errors++; $display("FAIL hold_dwell: got %0d cycles expected %0d", open_cycles, DWELL); end
      checks++;
      if (state !== 2'd0 || calls_pending !== 8'h00) begin
         errors++; $display("FAIL hold_idle: got state=%0d pending=%h expected 0 00", state, calls_pending);
      end
   endtask

   task automatic test_here_call();
      bit ok;
      tick(8'h01);
      run_to_idle(100, ok);
      checks++;
      if (!ok || current_floor !== 3'd0) begin errors++; $display("FAIL here_setup: got floor=%0d ok=%b expected floor=0", current_floor, ok); end
      tick(8'h01);
      checks++;
      if (state !== 2'd0 || calls_pending !== 8'h01) begin
         errors++; $display("FAIL here_latch: got state=%0d pending=%h expected 0 01", state, calls_pending);
      end
      tick(8'h00);
      checks++;
      if (state !== 2'd3 || current_floor !== 3'd0 || calls_pending !== 8'h00 || moving !== 1'b0) begin
         errors++; $display("FAIL here_door: got state=%0d floor=%0d pending=%h moving=%b expected 3 0 00 0",
                            state, current_floor, calls_pending, moving);
      end
   endtask

   task automatic test_async_reset();
      int n = 0;
      tick(8'h80);
      while (n < 100 && !(state == 2'd1 && current_floor == 3'd2)) begin tick(8'h00); n++; end
      checks++;
      if (state !== 2'd1 || current_floor !== 3'd2) begin
         errors++; $display("FAIL areset_setup: got state=%0d floor=%0d expected 1 2", state, current_floor);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs !== {2'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL areset_immediate: got %h expected %h", obs, {2'd0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0});
      end
      #2 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      bit ok;
      logic [7:0] req;
      for (int n = 0; n < 600; n++) begin
         req = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         tick(req);
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL random_model n=%0d: got %h expected %h", n, obs, exp_vec()); end
      end
      run_to_idle(400, ok);
      checks++;
      if (!ok || obs !== exp_vec()) begin
         errors++; $display("FAIL random_drain: got %h ok=%b expected %h", obs, ok, exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_sweep();
      test_mid_move_call();
      test_door_hold();
      test_here_call();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
